// File: rtl/tone_scheduler.sv
// Tone sequencer: queues {note, duration, rest} commands and plays them beat by beat,
// driving the note ROM index and the PWM gate.
module tone_scheduler #(
    parameter int DEPTH = 4,
    parameter int ARTIC = 1
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       beat_strb_i,
    input  logic                       play_en_i,
    input  logic                       flush_i,
    input  logic                       cmd_valid_i,
    output logic                       cmd_ready_o,
    input  logic [5:0]                 cmd_note_i,
    input  logic [3:0]                 cmd_dur_i,
    input  logic                       cmd_rest_i,
    output logic [5:0]                 note_index_o,
    output logic                       gate_o,
    output logic                       note_done_o,
    output logic                       busy_o,
    output logic [$clog2(DEPTH):0]     level_o
);

    // state | meaning
    // IDLE  | nothing playing; pops the FIFO head when running and non-empty
    // PLAY  | current command sounding (or resting), counting down beats
    // GAP   | one silent articulation beat after a command (ARTIC=1 only)

    localparam int PW = $clog2(DEPTH);
    localparam int LW = PW + 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        PLAY = 2'd1,
        GAP  = 2'd2
    } state_t;

    state_t        state, state_nxt;
    logic [10:0]   fifo_mem [DEPTH];
    logic [PW-1:0] wr_ptr, rd_ptr;
    logic [LW-1:0] level;
    logic [4:0]    remaining, remaining_nxt;
    logic          cur_rest, cur_rest_nxt;
    logic [5:0]    note_nxt;
    logic          done_nxt;
    logic          push, pop;
    logic [10:0]   head;
    logic          fifo_empty;

    assign cmd_ready_o = (level < LW'(DEPTH)) & ~flush_i;
    assign push        = cmd_valid_i & cmd_ready_o;
    assign head        = fifo_mem[rd_ptr];
    assign fifo_empty  = (level == '0);
    assign level_o     = level;
    assign busy_o      = (state != IDLE) | ~fifo_empty;
    assign gate_o      = (state == PLAY) & ~cur_rest & play_en_i;

    always_comb begin
        state_nxt     = state;
        remaining_nxt = remaining;
        cur_rest_nxt  = cur_rest;
        note_nxt      = note_index_o;
        done_nxt      = 1'b0;
        pop           = 1'b0;

        if (play_en_i) begin
            case (state)
                IDLE: begin
                    if (!fifo_empty) begin
                        pop           = 1'b1;
                        note_nxt      = head[10:5];
                        remaining_nxt = {~|head[4:1], head[4:1]};
                        cur_rest_nxt  = head[0];
                        state_nxt     = PLAY;
                    end
                end
                PLAY: begin
                    if (beat_strb_i) begin
                        if (remaining == 5'd1) begin
                            done_nxt = 1'b1;
                            if (ARTIC != 0) begin
                                remaining_nxt = '0;
                                state_nxt     = GAP;
                            end else if (!fifo_empty) begin
                                // back-to-back: the finishing strobe is not counted against the new command
                                pop           = 1'b1;
                                note_nxt      = head[10:5];
                                remaining_nxt = {~|head[4:1], head[4:1]};
                                cur_rest_nxt  = head[0];
                            end else begin
                                remaining_nxt = '0;
                                state_nxt     = IDLE;
                            end
                        end else begin
                            remaining_nxt = remaining - 5'd1;
                        end
                    end
                end
                GAP: begin
                    if (beat_strb_i) state_nxt = IDLE;
                end
                default: state_nxt = IDLE;
            endcase
        end

        if (flush_i) begin
            state_nxt     = IDLE;
            remaining_nxt = '0;
            cur_rest_nxt  = 1'b0;
            note_nxt      = '0;
            done_nxt      = 1'b0;
            pop           = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= IDLE;
            remaining    <= '0;
            cur_rest     <= 1'b0;
            note_index_o <= '0;
            note_done_o  <= 1'b0;
        end else begin
            state        <= state_nxt;
            remaining    <= remaining_nxt;
            cur_rest     <= cur_rest_nxt;
            note_index_o <= note_nxt;
            note_done_o  <= done_nxt;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else if (flush_i) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PW'(1);
            if (pop)  rd_ptr <= rd_ptr + PW'(1);
            case ({push, pop})
                2'b10:   level <= level + LW'(1);
                2'b01:   level <= level - LW'(1);
                default: level <= level;
            endcase
        end
    end

    // storage needs no reset: occupancy alone decides what is valid
    always_ff @(posedge clk) begin
        if (push) fifo_mem[wr_ptr] <= {cmd_note_i, cmd_dur_i, cmd_rest_i};
    end

endmodule
